// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream, INMEM write and status bundle of the program loader
// Signals:
//   start       host -> loader  1-cycle pulse starting a load
//   byte_valid  host -> loader  stream byte valid
//   byte_data   host -> loader  stream byte
//   byte_ready  loader -> host  byte accepted when byte_valid & byte_ready
//   imem_we     loader -> mem   INMEM byte write strobe
//   imem_addr   loader -> mem   INMEM byte address
//   imem_wdata  loader -> mem   INMEM byte data
//   cpu_reset   loader -> core  active-high core reset, low only once the image is in
//   busy/done/error             load status levels
// master: host/testbench side; slave: loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader writing INMEM and holding the core in reset
// Ports:
//   clk    core clock
//   reset  synchronous active-low reset
//   bus    imem_loader_if.slave (stream in, INMEM write out, cpu_reset/busy/done/error out)
// Stream: LEN_LO, LEN_HI (N words), then 4*N bytes, byte k -> INMEM[k].
// Optional feature macro LOADER_CHECKSUM_EN: adds a trailing XOR checksum byte (CHK state).
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif
  localparam logic [15:0]       MAXW = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ONE  = 1;
  state_t            r_state, w_next;
  logic              r_done;
  logic              r_we;
  logic [ADDR_W-1:0] r_cnt, r_addr, w_last_idx;
  logic [ADDR_W-3:0] r_nw;
  logic [7:0]        r_lo, r_wdata;
  logic [15:0]       w_len;
  logic              w_acc, w_rx;
  assign w_acc = bus.byte_valid & bus.byte_ready;
  assign w_len = {bus.byte_data, r_lo};
  // N == 2**(ADDR_W-2) truncates to 0 in r_nw; 0 - 1 still gives the right last index
  assign w_last_idx = {r_nw, 2'b00} - ONE;
`ifdef LOADER_CHECKSUM_EN
  assign w_rx = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  logic [7:0] r_chk;
  always_ff @(posedge clk)
    if (!reset) r_chk <= '0;
    else if (w_acc) r_chk <= (r_state == S_LEN_LO) ? bus.byte_data : r_chk ^ bus.byte_data;
`else
  assign w_rx = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA};
`endif
  // r_done rises one cycle after entering DONE so the last INMEM write lands before the core runs
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE) && (w_next == S_DONE);
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (bus.start) w_next = S_LEN_LO;
      S_LEN_LO: if (w_acc) w_next = S_LEN_HI;
      S_LEN_HI: if (w_acc) w_next = (w_len == 16'd0) ? S_END : (w_len > MAXW) ? S_ERR : S_DATA;
      S_DATA: if (w_acc && r_cnt == w_last_idx) w_next = S_END;
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (w_acc) w_next = (bus.byte_data == r_chk) ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.byte_ready = w_rx;
    bus.busy       = w_rx || (r_state == S_DONE && !r_done);
    bus.done       = r_done;
    bus.error      = r_state == S_ERR;
    bus.cpu_reset  = !r_done;
    bus.imem_we    = r_we;
    bus.imem_addr  = r_addr;
    bus.imem_wdata = r_wdata;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_cnt   <= '0;
      r_nw    <= '0;
      r_lo    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_acc && (r_state == S_DATA);
      if (w_acc && r_state == S_LEN_LO) r_lo <= bus.byte_data;
      if (w_acc && r_state == S_LEN_HI) begin
        r_nw  <= w_len[ADDR_W-3:0];
        r_cnt <= '0;
      end
      if (w_acc && r_state == S_DATA) begin
        r_addr  <= r_cnt;
        r_wdata <= bus.byte_data;
        r_cnt   <= r_cnt + ONE;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0] mem [0:255];
  logic [7:0] log_a [0:1023];
  logic [7:0] img [0:255];
  logic [5:0] st;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [5:0] ST_END = 6'b001100;
`else
  localparam logic [5:0] ST_END = 6'b011100;
`endif
  localparam logic [5:0] ST_RST  = 6'b001000;
  localparam logic [5:0] ST_LOAD = 6'b101100;
  localparam logic [5:0] ST_DONE = 6'b000010;
  localparam logic [5:0] ST_ERR  = 6'b001001;
  imem_loader_if #(.ADDR_W(8)) bus ();
  imem_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // status vector: {byte_ready, imem_we, cpu_reset, busy, done, error}
  assign st = {bus.byte_ready, bus.imem_we, bus.cpu_reset, bus.busy, bus.done, bus.error};
  always @(posedge clk)
    if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
      log_a[wr_cnt]      <= bus.imem_addr;
      wr_cnt             <= wr_cnt + 1;
    end
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) repeat ($urandom_range(0, 1)) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!bus.byte_ready) begin
      errors++;
      $display("FAIL send_byte_timeout byte=%h ready=%b need 1", b, bus.byte_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask
  task automatic load_image(input int n, input bit gap);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4 * n; i++) x ^= img[i];
`endif
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < 4 * n; i++) send_byte(img[i], gap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, gap);
`endif
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (st !== ST_RST) begin errors++; $display("FAIL reset_status got %b want %b", st, ST_RST); end
    if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.imem_addr); end
    if (bus.imem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", bus.imem_wdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_load2;
    int w0 = wr_cnt;
    logic [7:0] v [0:7] = '{8'hb3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82, 8'h11, 8'h40};
    for (int i = 0; i < 8; i++) img[i] = v[i];
    pulse_start;
    checks++;
    if (st !== ST_LOAD) begin errors++; $display("FAIL load2_start got %b want %b", st, ST_LOAD); end
    load_image(2, 0);
    checks++;
    if (st !== ST_END) begin errors++; $display("FAIL load2_last got %b want %b", st, ST_END); end
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL load2_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL load2_writes got %0d want 8", wr_cnt - w0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_a[w0+i] !== 8'(i) || mem[i] !== v[i]) begin
        errors++;
        $display("FAIL load2_byte%0d got addr %h data %h want addr %h data %h", i, log_a[w0+i], mem[i], 8'(i), v[i]);
      end
    end
  endtask
  task automatic test_zero_overflow;
    int w0 = wr_cnt;
    pulse_start;
    checks++;
    if (st !== ST_LOAD) begin errors++; $display("FAIL restart_from_done got %b want %b", st, ST_LOAD); end
    load_image(0, 0);
    checks++;
    if (st !== 6'b001100) begin errors++; $display("FAIL zero_pending got %b want 001100", st); end
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL zero_done got %b want %b", st, ST_DONE); end
    if (wr_cnt !== w0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_cnt - w0); end
    pulse_start;
    send_byte(8'd65, 0);
    send_byte(8'd0, 0);
    checks++;
    if (st !== ST_ERR) begin errors++; $display("FAIL ovf_err got %b want %b", st, ST_ERR); end
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'haa;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    checks += 2;
    if (st !== ST_ERR) begin errors++; $display("FAIL ovf_hold got %b want %b", st, ST_ERR); end
    if (wr_cnt !== w0) begin errors++; $display("FAIL ovf_writes got %0d want 0", wr_cnt - w0); end
  endtask
  task automatic test_gaps;
    int w0 = wr_cnt;
    for (int i = 0; i < 16; i++) img[i] = 8'(i * 37 + 5);
    pulse_start;
    checks++;
    if (st !== ST_LOAD) begin errors++; $display("FAIL restart_from_err got %b want %b", st, ST_LOAD); end
    load_image(4, 1);
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL gaps_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 16) begin errors++; $display("FAIL gaps_writes got %0d want 16", wr_cnt - w0); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (log_a[w0+i] !== 8'(i) || mem[i] !== 8'(i * 37 + 5)) begin
        errors++;
        $display("FAIL gaps_byte%0d got addr %h data %h want addr %h data %h", i, log_a[w0+i], mem[i], 8'(i), 8'(i * 37 + 5));
      end
    end
  endtask
  task automatic test_reset_mid;
    int w0;
    for (int i = 0; i < 8; i++) img[i] = 8'(8'hc0 + i);
    pulse_start;
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 5; i++) send_byte(img[i], 0);
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (st !== ST_RST) begin errors++; $display("FAIL midreset_status got %b want %b", st, ST_RST); end
    if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL midreset_addr got %h want 00", bus.imem_addr); end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) img[i] = 8'(8'h50 + i);
    w0 = wr_cnt;
    pulse_start;
    load_image(2, 0);
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL reload_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 8) begin errors++; $display("FAIL reload_writes got %0d want 8", wr_cnt - w0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_a[w0+i] !== 8'(i) || mem[i] !== 8'(8'h50 + i)) begin
        errors++;
        $display("FAIL reload_byte%0d got addr %h data %h want addr %h data %h", i, log_a[w0+i], mem[i], 8'(i), 8'(8'h50 + i));
      end
    end
  endtask
  task automatic test_start_mid;
    int w0 = wr_cnt;
    logic [7:0] v [0:3] = '{8'h11, 8'h22, 8'h44, 8'h88};
    pulse_start;
    send_byte(8'd1, 0);
    send_byte(8'd0, 0);
    send_byte(v[0], 0);
    send_byte(v[1], 0);
    pulse_start;
    checks++;
    if (st !== ST_LOAD) begin errors++; $display("FAIL midstart_status got %b want %b", st, ST_LOAD); end
    send_byte(v[2], 0);
    send_byte(v[3], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'hff, 0);
`endif
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL midstart_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL midstart_writes got %0d want 4", wr_cnt - w0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_a[w0+i] !== 8'(i) || mem[i] !== v[i]) begin
        errors++;
        $display("FAIL midstart_byte%0d got addr %h data %h want addr %h data %h", i, log_a[w0+i], mem[i], 8'(i), v[i]);
      end
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart got cpu_reset %b done %b want 1 0", bus.cpu_reset, bus.done);
    end
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) img[i] = 8'(8'hf0 - i);
    load_image(1, 0);
    @(negedge clk);
    checks += 2;
    if (st !== ST_DONE) begin errors++; $display("FAIL second_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 4 || mem[3] !== 8'hed) begin
      errors++;
      $display("FAIL second_writes got %0d mem3 %h want 4 ed", wr_cnt - w0, mem[3]);
    end
  endtask
  task automatic test_max;
    int w0 = wr_cnt;
    int bad = 0;
    for (int i = 0; i < 256; i++) img[i] = 8'(i) ^ 8'h5a;
    pulse_start;
    load_image(64, 0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) if (log_a[w0+i] !== 8'(i) || mem[i] !== (8'(i) ^ 8'h5a)) bad++;
    checks += 3;
    if (st !== ST_DONE) begin errors++; $display("FAIL max_done got %b want %b", st, ST_DONE); end
    if (wr_cnt - w0 !== 256) begin errors++; $display("FAIL max_writes got %0d want 256", wr_cnt - w0); end
    if (bad !== 0) begin errors++; $display("FAIL max_contents got %0d bad bytes want 0", bad); end
  endtask
`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] v [0:5] = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start;
    for (int i = 0; i < 6; i++) send_byte(v[i], 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    checks++;
    if (st !== ST_DONE) begin errors++; $display("FAIL chk_match got %b want %b", st, ST_DONE); end
    pulse_start;
    for (int i = 0; i < 6; i++) send_byte(v[i], 0);
    send_byte(8'h06, 0);
    checks++;
    if (st !== ST_ERR) begin errors++; $display("FAIL chk_mismatch got %b want %b", st, ST_ERR); end
  endtask
`endif
  initial begin
    test_reset;
    test_load2;
    test_zero_overflow;
    test_gaps;
    test_reset_mid;
    test_start_mid;
    test_max;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
